qspi_mem_scheduler: RTL and testbench
=====================================

// Module: qspi_mem_scheduler
// PURPOSE
// Two-port QSPI master that shares the single QSPI bus (flash, RAM A, RAM B) between instruction
// fetch (port 0) and data load/store (port 1). Arbitrates round-robin, serialises command, address,
// dummy and data nibbles, and returns 1/2/4-byte results. Sits between the CPU bus and the QSPI pads.
// PARAMETERS
// CS_IDLE_CYC  2  minimum clk cycles all selects stay high between transactions (>=1)
// FLASH_DUMMY  6  dummy nibbles after flash address
// RAM_DUMMY    4  dummy nibbles after RAM 0x0B read command+address
// PORTS
// clk             in   1   system clock; all logic on posedge
// rst             in   1   synchronous reset, active high
// req0/req1       in   1   request; held high with operands stable until matching ack
// addr0/addr1     in   25  byte address; [24:23] 00/01 flash, 10 RAM A, 11 RAM B; [22:0] device addr
// size0/size1     in   2   00 1 byte, 01 2 bytes, 10 4 bytes (11 treated as 4)
// we1             in   1   port 1 write (port 0 read-only)
// wdata1          in   32  write data, little-endian, byte 0 = [7:0]
// ack0/ack1       out  1   one-cycle completion pulse
// err0/err1       out  1   one-cycle pulse with ack: write to flash rejected, no bus activity
// rdata0/rdata1   out  32  read data, valid with ack, unused upper bytes zero; held until next ack
// qspi_clk        out  1   SPI clock = clk/2 during transaction, low when idle
// qspi_data_out   out  4   nibble to memory
// qspi_data_oe    out  4   4'hF except during dummy/data phase of reads (4'h0)
// qspi_data_in    in   4   nibble from memory
// qspi_flash_select/qspi_ram_a_select/qspi_ram_b_select  out 1 each, active low
// busy            out  1   high from grant to end of CS idle gap
// BEHAVIOUR
// - Reset: FSM IDLE, all selects 1, qspi_clk 0, data_out 0, oe 4'hF, ack/err 0, rdata 0, busy 0,
//   round-robin pointer favours port 0.
// - Arbitration in IDLE only: one requester -> grant it; both -> grant the one not last served.
//   Grant held to completion; a request dropped mid-transaction is still completed (ack discarded by bus).
// - States: IDLE -> CMD -> ADDR -> DUMMY (reads) -> DATA -> GAP -> IDLE.
//   Flash: no CMD phase; ADDR = 6 nibbles addr[22:0] zero-extended MSB first; DUMMY FLASH_DUMMY.
//   RAM: CMD = 2 nibbles 0x0B read / 0x02 write; ADDR 6 nibbles; read DUMMY RAM_DUMMY; write none.
// - Each nibble = 2 clk: cycle A drives qspi_data_out with qspi_clk=0, cycle B sets qspi_clk=1;
//   reads sample qspi_data_in in cycle B. Select asserted one cycle before first nibble.
// - DATA: 2*bytes nibbles, high nibble of each byte first, byte order ascending address.
//   Read data assembled little-endian into rdata.
// - End: deassert select and qspi_clk=0 same cycle; ack (and rdata) pulse that cycle; GAP lasts
//   CS_IDLE_CYC cycles; new grant only after GAP.
// - Flash write (we1 & addr1[24]=0): ack1+err1 next cycle from IDLE, no select, pointer updated.
// - Nibble counter 5 bits, no wrap within a transaction; device address wrap is memory's concern.
// - rst mid-transaction: immediate return to reset state, selects high, no ack.
// TESTING
// - Port0 read flash addr 0x000010 size 10, memory bytes 11 22 33 44 -> nibbles out 0,0,0,0,1,0,
//   6 dummy, ack0 with rdata0=0x44332211, flash_select low exactly 20 qspi_clk pulses.
// - Port1 write RAM A 0x1000123 size 01 wdata 0xBEEF -> out 0,2,0,0,0,1,2,3,E,F,B,E; ack1; readback=0xBEEF.
// - Port1 read RAM B addr 0x1800004 size 00 -> cmd 0,B, 4 dummy with oe=0, rdata1=0x000000XX.
// - req0 and req1 both high continuously -> grants alternate 0,1,0,1; >=CS_IDLE_CYC gap between selects.
// - Port1 we1 to flash 0x0000100 -> ack1 & err1 one cycle, all selects stay high.
// - Assert rst during DATA of a 4-byte read -> selects high next cycle, no ack, next request works normally.

Source files
------------

// File: rtl/qspi_mem_scheduler.sv
// rtl/qspi_mem_scheduler.sv - two-port round-robin QSPI master for flash, RAM A and RAM B
module qspi_mem_scheduler #(
  parameter int CS_IDLE_CYC = 2,
  parameter int FLASH_DUMMY = 6,
  parameter int RAM_DUMMY   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [24:0] addr0_i,
  input  logic [24:0] addr1_i,
  input  logic [1:0]  size0_i,
  input  logic [1:0]  size1_i,
  input  logic        we1_i,
  input  logic [31:0] wdata1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        qspi_clk_o,
  output logic [3:0]  qspi_data_out_o,
  output logic [3:0]  qspi_data_oe_o,
  input  logic [3:0]  qspi_data_in_i,
  output logic        qspi_flash_select_o,
  output logic        qspi_ram_a_select_o,
  output logic        qspi_ram_b_select_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP
  } state_t;

  localparam logic [7:0] GAP_LAST  = 8'(CS_IDLE_CYC - 1);
  localparam logic [4:0] FL_DUMMY  = 5'(FLASH_DUMMY);
  localparam logic [4:0] RM_DUMMY  = 5'(RAM_DUMMY);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ph_q, ph_d;
  logic        port_q, port_d;
  logic        prio_q, prio_d;
  logic        we_q, we_d;
  logic [1:0]  dev_q, dev_d;
  logic [22:0] addr_q, addr_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_q, rd_d;
  logic [7:0]  gap_q, gap_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        gnt_port;
  logic [24:0] gnt_addr;
  logic [1:0]  gnt_size;
  logic        gnt_we;
  logic [4:0]  dummy_len;
  logic [4:0]  phase_last;
  logic [4:0]  data_idx;
  logic [4:0]  addr_idx;
  logic [23:0] addr24;
  logic [7:0]  cmd_byte;

  // When both ports request, the one not served last wins
  assign gnt_port  = (req0_i && req1_i) ? prio_q : req1_i;
  assign gnt_addr  = gnt_port ? addr1_i : addr0_i;
  assign gnt_size  = gnt_port ? size1_i : size0_i;
  assign gnt_we    = gnt_port & we1_i;

  assign dummy_len = dev_q[1] ? RM_DUMMY : FL_DUMMY;
  // Data nibble position: byte = cnt/2, high nibble on even counts
  assign data_idx  = {cnt_q[2:1], ~cnt_q[0], 2'b00};
  assign addr_idx  = 5'd20 - {cnt_q[2:0], 2'b00};
  assign addr24    = {1'b0, addr_q};
  assign cmd_byte  = we_q ? 8'h02 : 8'h0B;

  // Last nibble index of the phase currently being shifted
  always_comb begin
    phase_last = 5'd0;
    case (state_q)
      S_CMD:   phase_last = 5'd1;
      S_ADDR:  phase_last = 5'd5;
      S_DUMMY: phase_last = dummy_len - 5'd1;
      S_DATA:  phase_last = len_q - 5'd1;
      default: phase_last = 5'd0;
    endcase
  end

  // Next-state: arbitration, phase sequencing, read assembly and completion
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    port_d   = port_q;
    prio_d   = prio_q;
    we_d     = we_q;
    dev_d    = dev_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    gap_d    = gap_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          prio_d  = ~gnt_port;
          port_d  = gnt_port;
          we_d    = gnt_we;
          dev_d   = gnt_addr[24] ? gnt_addr[24:23] : 2'b00;
          addr_d  = gnt_addr[22:0];
          wdata_d = wdata1_i;
          case (gnt_size)
            2'b00:   len_d = 5'd2;
            2'b01:   len_d = 5'd4;
            default: len_d = 5'd8;
          endcase
          cnt_d = 5'd0;
          ph_d  = 1'b0;
          rd_d  = 32'd0;
          gap_d = 8'd0;
          if (gnt_we && !gnt_addr[24]) begin
            // Flash is read-only: answer at once and never touch the bus
            ack1_d  = 1'b1;
            err1_d  = 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_SEL;
          end
        end
      end
      S_SEL: state_d = dev_q[1] ? S_CMD : S_ADDR;
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (state_q == S_DATA && !we_q) begin
            rd_d = rd_q | (32'(qspi_data_in_i) << data_idx);
          end
          if (cnt_q == phase_last) begin
            cnt_d = 5'd0;
            case (state_q)
              S_CMD:   state_d = S_ADDR;
              S_ADDR:  state_d = (we_q || dummy_len == 5'd0) ? S_DATA : S_DUMMY;
              S_DUMMY: state_d = S_DATA;
              default: begin
                state_d = S_GAP;
                gap_d   = 8'd0;
                if (port_q) begin
                  ack1_d = 1'b1;
                  if (!we_q) rdata1_d = rd_d;
                end else begin
                  ack0_d   = 1'b1;
                  rdata0_d = rd_d;
                end
              end
            endcase
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q >= GAP_LAST) state_d = S_IDLE;
        else gap_d = gap_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      ph_q     <= 1'b0;
      port_q   <= 1'b0;
      prio_q   <= 1'b0;
      we_q     <= 1'b0;
      dev_q    <= 2'b00;
      addr_q   <= 23'd0;
      len_q    <= 5'd0;
      wdata_q  <= 32'd0;
      rd_q     <= 32'd0;
      gap_q    <= 8'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      port_q   <= port_d;
      prio_q   <= prio_d;
      we_q     <= we_d;
      dev_q    <= dev_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      gap_q    <= gap_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Pad decode: select, SPI clock in cycle B, nibble mux and output enable
  always_comb begin
    qspi_clk_o          = 1'b0;
    qspi_data_out_o     = 4'h0;
    qspi_data_oe_o      = 4'hF;
    qspi_flash_select_o = 1'b1;
    qspi_ram_a_select_o = 1'b1;
    qspi_ram_b_select_o = 1'b1;
    if (state_q inside {S_SEL, S_CMD, S_ADDR, S_DUMMY, S_DATA}) begin
      qspi_flash_select_o = dev_q[1];
      qspi_ram_a_select_o = !(dev_q == 2'b10);
      qspi_ram_b_select_o = !(dev_q == 2'b11);
    end
    if (state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA}) qspi_clk_o = ph_q;
    case (state_q)
      S_CMD:   qspi_data_out_o = cnt_q[0] ? cmd_byte[3:0] : cmd_byte[7:4];
      S_ADDR:  qspi_data_out_o = 4'(addr24 >> addr_idx);
      S_DUMMY: qspi_data_oe_o  = 4'h0;
      S_DATA: begin
        if (we_q) qspi_data_out_o = 4'(wdata_q >> data_idx);
        else qspi_data_oe_o = 4'h0;
      end
      default: qspi_data_out_o = 4'h0;
    endcase
  end

  assign ack0_o   = ack0_q;
  assign ack1_o   = ack1_q;
  assign err0_o   = err0_q;
  assign err1_o   = err1_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_qspi_mem_scheduler.sv
// tb/tb_qspi_mem_scheduler.sv - scoreboard bench for qspi_mem_scheduler with a QSPI memory model
module tb_qspi_mem_scheduler;

  localparam int CS_IDLE_CYC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, we1 = 0;
  logic [24:0] addr0 = '0, addr1 = '0;
  logic [1:0]  size0 = '0, size1 = '0;
  logic [31:0] wdata1 = '0;
  logic [3:0]  din = 4'h0;
  logic        ack0, ack1, err0, err1, qclk, fs, ras, rbs, busy;
  logic [31:0] rdata0, rdata1;
  logic [3:0]  dout, oe;

  qspi_mem_scheduler #(.CS_IDLE_CYC(CS_IDLE_CYC), .FLASH_DUMMY(6), .RAM_DUMMY(4)) dut (
    .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
    .addr0_i(addr0), .addr1_i(addr1), .size0_i(size0), .size1_i(size1),
    .we1_i(we1), .wdata1_i(wdata1), .ack0_o(ack0), .ack1_o(ack1),
    .err0_o(err0), .err1_o(err1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .qspi_clk_o(qclk), .qspi_data_out_o(dout), .qspi_data_oe_o(oe),
    .qspi_data_in_i(din), .qspi_flash_select_o(fs), .qspi_ram_a_select_o(ras),
    .qspi_ram_b_select_o(rbs), .busy_o(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } exp_t;

  exp_t exp0_q[$];
  exp_t exp1_q[$];
  int   ack_order[$];

  // Memory contents keyed by {device, 23-bit address}; device 0 flash, 2 RAM A, 3 RAM B
  logic [7:0] mem [int];

  function automatic logic [7:0] mem_rd(input int key);
    if (mem.exists(key)) return mem[key];
    return 8'h00;
  endfunction

  function automatic int key_of(input logic [24:0] a);
    int dev;
    dev = a[24] ? int'(a[24:23]) : 0;
    return dev * (1 << 23) + int'(a[22:0]);
  endfunction

  function automatic logic [31:0] exp_read(input logic [24:0] a, input logic [1:0] sz);
    int n;
    logic [31:0] r;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = mem_rd(key_of(a) + i);
    return r;
  endfunction

  // Bus model state
  bit         in_txn = 0, had_txn = 0;
  logic [3:0] nibs[$];
  logic [3:0] last_nibs[$];
  int pulses = 0, oe0 = 0, hi_cnt = 0, txn_count = 0, cur_dev = 0;
  int last_pulses = 0, last_oe0 = 0, last_dev = -1;

  function automatic int base_addr();
    int off, a;
    off = (cur_dev == 0) ? 0 : 2;
    a = 0;
    for (int i = 0; i < 6; i++) a = (a << 4) | int'(nibs[off+i]);
    return a & 32'h7FFFFF;
  endfunction

  function automatic logic [63:0] pack_nibs();
    logic [63:0] v = '0;
    foreach (last_nibs[i]) v = (v << 4) | 64'(last_nibs[i]);
    return v;
  endfunction

  exp_t       mon_e;
  int         mon_k;
  logic [7:0] mon_b;

  // Scoreboard pop on ack, plus a QSPI memory that answers reads and absorbs RAM writes
  always @(negedge clk) begin
    if (ack0) begin
      ack_order.push_back(0);
      if (exp0_q.size() == 0) check_val("ack0_unexpected", 1, 0);
      else begin
        mon_e = exp0_q.pop_front();
        check_val("err0", 64'(err0), 64'(mon_e.err));
        if (mon_e.chk_rd) check_val("rdata0", 64'(rdata0), 64'(mon_e.rdata));
      end
    end
    if (ack1) begin
      ack_order.push_back(1);
      if (exp1_q.size() == 0) check_val("ack1_unexpected", 1, 0);
      else begin
        mon_e = exp1_q.pop_front();
        check_val("err1", 64'(err1), 64'(mon_e.err));
        if (mon_e.chk_rd) check_val("rdata1", 64'(rdata1), 64'(mon_e.rdata));
      end
    end
    if (err0 && !ack0) check_val("err0_without_ack", 1, 0);
    if (err1 && !ack1) check_val("err1_without_ack", 1, 0);
    if (!(fs && ras && rbs)) begin
      if (!in_txn) begin
        in_txn = 1;
        nibs.delete();
        pulses = 0;
        oe0 = 0;
        cur_dev = !fs ? 0 : (!ras ? 2 : 3);
        if (had_txn) check_val("cs_gap", 64'(hi_cnt >= CS_IDLE_CYC), 1);
      end
      hi_cnt = 0;
      if (qclk) begin
        if (oe == 4'hF) nibs.push_back(dout);
        else begin
          oe0++;
          if (pulses >= 12) begin
            mon_k = pulses - 12;
            mon_b = mem_rd(cur_dev * (1 << 23) + base_addr() + mon_k / 2);
            din = (mon_k % 2 == 0) ? mon_b[7:4] : mon_b[3:0];
          end else begin
            din = 4'($urandom);
          end
        end
        pulses++;
      end
    end else begin
      hi_cnt++;
      if (in_txn) begin
        if (cur_dev != 0 && nibs.size() >= 8 && nibs[0] == 4'h0 && nibs[1] == 4'h2) begin
          for (int i = 0; i < (nibs.size() - 8) / 2; i++)
            mem[cur_dev * (1 << 23) + base_addr() + i] = {nibs[8+2*i], nibs[9+2*i]};
        end
        last_nibs = nibs;
        last_pulses = pulses;
        last_oe0 = oe0;
        last_dev = cur_dev;
        txn_count++;
        in_txn = 0;
        had_txn = 1;
      end
    end
  end

  task automatic do_req(input int port, input logic [24:0] a, input logic [1:0] sz,
                        input logic w, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic chk_rd);
    exp_t e;
    bit seen;
    e.rdata = exp_rd;
    e.err = exp_err;
    e.chk_rd = chk_rd;
    if (port == 0) begin
      exp0_q.push_back(e); addr0 = a; size0 = sz; req0 = 1;
    end else begin
      exp1_q.push_back(e); addr1 = a; size1 = sz; we1 = w; wdata1 = wd; req1 = 1;
    end
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = (port == 0) ? ack0 : ack1;
    end
    if (port == 0) req0 = 0; else req1 = 0;
    if (!seen) begin
      check_val("ack_timeout", 0, 1);
      if (port == 0) void'(exp0_q.pop_back()); else void'(exp1_q.pop_back());
    end else begin
      @(negedge clk);
      check_val("ack_one_cycle", 64'((port == 0) ? ack0 : ack1), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int tc;
  bit hit;

  initial begin
    mem[32'h10] = 8'h11; mem[32'h11] = 8'h22; mem[32'h12] = 8'h33; mem[32'h13] = 8'h44;
    mem[3 * (1 << 23) + 4] = 8'h5A;
    mem[32'h20] = 8'hA1; mem[32'h21] = 8'hB2; mem[32'h22] = 8'hC3; mem[32'h23] = 8'hD4;
    mem[32'h24] = 8'h55; mem[32'h25] = 8'h66;
    mem[2 * (1 << 23) + 32'h40] = 8'h01; mem[2 * (1 << 23) + 32'h41] = 8'h02;
    mem[2 * (1 << 23) + 32'h42] = 8'h03; mem[2 * (1 << 23) + 32'h43] = 8'h04;
    mem[2 * (1 << 23) + 32'h44] = 8'h99;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_val("reset_pads", {fs, ras, rbs, qclk, dout, oe, ack0, ack1, err0, err1, busy},
              {3'b111, 1'b0, 4'h0, 4'hF, 5'b0});
    check_val("reset_rdata", {rdata0, rdata1}, 64'h0);

    // Flash quad read, 4 bytes
    do_req(0, 25'h0000010, 2'b10, 0, 0, 32'h44332211, 0, 1);
    check_val("flash_addr_nibs", pack_nibs(), 64'h000010);
    check_val("flash_clk_pulses", 64'(last_pulses), 20);
    check_val("flash_oe_low_nibs", 64'(last_oe0), 14);
    check_val("flash_dev", 64'(last_dev), 0);

    // RAM A write, 2 bytes, then readback
    do_req(1, 25'h1000123, 2'b01, 1, 32'h0000BEEF, 0, 0, 0);
    check_val("rama_wr_nibs", pack_nibs(), 64'h02000123EFBE);
    check_val("rama_wr_pulses", 64'(last_pulses), 12);
    check_val("rama_wr_oe_low", 64'(last_oe0), 0);
    check_val("rama_wr_dev", 64'(last_dev), 2);
    check_val("rama_mem", {mem_rd(2 * (1 << 23) + 32'h124), mem_rd(2 * (1 << 23) + 32'h123)}, 16'hBEEF);
    do_req(1, 25'h1000123, 2'b01, 0, 0, 32'h0000BEEF, 0, 1);

    // RAM B single byte read
    do_req(1, 25'h1800004, 2'b00, 0, 0, 32'h0000005A, 0, 1);
    check_val("ramb_rd_nibs", pack_nibs(), 64'h0B000004);
    check_val("ramb_rd_oe_low", 64'(last_oe0), 6);
    check_val("ramb_rd_pulses", 64'(last_pulses), 14);
    check_val("ramb_dev", 64'(last_dev), 3);

    // Write to flash is rejected without bus activity
    tc = txn_count;
    do_req(1, 25'h0000100, 2'b10, 1, 32'h12345678, 0, 1, 0);
    check_val("flash_wr_no_select", 64'(txn_count), 64'(tc));

    // Both ports requesting back to back alternate
    ack_order.delete();
    fork
      begin
        do_req(0, 25'h0000020, 2'b10, 0, 0, exp_read(25'h0000020, 2'b10), 0, 1);
        do_req(0, 25'h0000024, 2'b01, 0, 0, exp_read(25'h0000024, 2'b01), 0, 1);
      end
      begin
        do_req(1, 25'h1000040, 2'b10, 0, 0, exp_read(25'h1000040, 2'b10), 0, 1);
        do_req(1, 25'h1000044, 2'b00, 0, 0, exp_read(25'h1000044, 2'b00), 0, 1);
      end
    join
    check_val("alt_count", 64'(ack_order.size()), 4);
    if (ack_order.size() == 4)
      check_val("alt_order", {ack_order[0][3:0], ack_order[1][3:0], ack_order[2][3:0], ack_order[3][3:0]}, 16'h0101);

    // Reset during the data phase of a 4-byte flash read
    addr0 = 25'h0000010; size0 = 2'b10; req0 = 1;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = in_txn && pulses >= 14;
    end
    check_val("reached_data_phase", 64'(hit), 1);
    @(posedge clk);
    #1 rst = 1; req0 = 0;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_mid_pads", {fs, ras, rbs, qclk, oe, busy, ack0}, {3'b111, 1'b0, 4'hF, 2'b00});
    check_val("rst_mid_rdata0", 64'(rdata0), 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (3) @(negedge clk);
    do_req(0, 25'h0000010, 2'b10, 0, 0, 32'h44332211, 0, 1);
    check_val("post_rst_pulses", 64'(last_pulses), 20);

    repeat (5) @(negedge clk);
    check_val("scoreboard_empty", 64'(exp0_q.size() + exp1_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
